// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one main-memory port between the I-cache (port 0)
// and the D-cache (port 1); a grant lasts for one cache-block burst or until the port releases.
module mem_arbiter #(
    parameter int BURST_WORDS   = 4,
    parameter int WORD_SIZE_BIT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_0,
    input  logic                     write_0,
    input  logic [WORD_SIZE_BIT-1:0] addr_0,
    input  logic [WORD_SIZE_BIT-1:0] wdata_0,
    output logic [WORD_SIZE_BIT-1:0] rdata_0,
    output logic                     ready_0,
    input  logic                     read_1,
    input  logic                     write_1,
    input  logic [WORD_SIZE_BIT-1:0] addr_1,
    input  logic [WORD_SIZE_BIT-1:0] wdata_1,
    output logic [WORD_SIZE_BIT-1:0] rdata_1,
    output logic                     ready_1,
    output logic                     gnt_0,
    output logic                     gnt_1,
    output logic                     read_mem,
    output logic                     write_mem,
    output logic [WORD_SIZE_BIT-1:0] addr_mem,
    output logic [WORD_SIZE_BIT-1:0] data_mem_out,
    input  logic [WORD_SIZE_BIT-1:0] data_mem_in,
    input  logic                     ready_mem
);

    localparam int CW = $clog2(BURST_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            last_grant_q;
    logic            gnt_0_q;
    logic            gnt_1_q;

    logic req_0;
    logic req_1;
    logic burst_last;

    assign req_0      = read_0 | write_0;
    assign req_1      = read_1 | write_1;
    assign burst_last = ready_mem && (cnt_q == CW'(BURST_WORDS - 1));
    assign cnt_d      = cnt_q + 1'b1;

    assign gnt_0 = gnt_0_q;
    assign gnt_1 = gnt_1_q;

    // Leaving a grant always lands in IDLE, which gives the one-cycle bus turnaround.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            gnt_0_q      <= 1'b0;
            gnt_1_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_0 && (!req_1 || last_grant_q)) begin
                        state_q      <= GRANT0;
                        gnt_0_q      <= 1'b1;
                        last_grant_q <= 1'b0;
                        cnt_q        <= '0;
                    end else if (req_1) begin
                        state_q      <= GRANT1;
                        gnt_1_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                GRANT0: begin
                    if (!req_0 || burst_last) begin
                        state_q <= IDLE;
                        gnt_0_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (ready_mem) begin
                        cnt_q <= cnt_d;
                    end
                end
                GRANT1: begin
                    if (!req_1 || burst_last) begin
                        state_q <= IDLE;
                        gnt_1_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (ready_mem) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_0_q <= 1'b0;
                    gnt_1_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Memory side follows the granted port combinationally; write wins over read.
    always_comb begin
        read_mem     = 1'b0;
        write_mem    = 1'b0;
        addr_mem     = '0;
        data_mem_out = '0;
        ready_0      = 1'b0;
        ready_1      = 1'b0;
        rdata_0      = '0;
        rdata_1      = '0;
        case (state_q)
            GRANT0: begin
                addr_mem     = addr_0;
                data_mem_out = wdata_0;
                write_mem    = write_0;
                read_mem     = read_0 & ~write_0;
                ready_0      = ready_mem;
                rdata_0      = data_mem_in;
            end
            GRANT1: begin
                addr_mem     = addr_1;
                data_mem_out = wdata_1;
                write_mem    = write_1;
                read_mem     = read_1 & ~write_1;
                ready_1      = ready_mem;
                rdata_1      = data_mem_in;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bursts, round robin, mid-burst contention, early release,
// asynchronous reset mid-burst and simultaneous read/write.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_0, write_0, read_1, write_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
    logic [31:0] rdata_0, rdata_1;
    logic        ready_0, ready_1, gnt_0, gnt_1;
    logic        read_mem, write_mem;
    logic [31:0] addr_mem, data_mem_out, data_mem_in;
    logic        ready_mem;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.BURST_WORDS(4), .WORD_SIZE_BIT(32)) dut (
        .clk(clk), .reset(reset),
        .read_0(read_0), .write_0(write_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0), .ready_0(ready_0),
        .read_1(read_1), .write_1(write_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1), .ready_1(ready_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .read_mem(read_mem), .write_mem(write_mem), .addr_mem(addr_mem),
        .data_mem_out(data_mem_out), .data_mem_in(data_mem_in), .ready_mem(ready_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"}, {30'b0, gnt_1, gnt_0}, 32'd0);
        check({tag, ".rw_mem"}, {30'b0, read_mem, write_mem}, 32'd0);
        check({tag, ".addr_mem"}, addr_mem, 32'd0);
        check({tag, ".rdy"}, {30'b0, ready_1, ready_0}, 32'd0);
        check({tag, ".rdata"}, rdata_0 | rdata_1, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        {read_0, write_0, read_1, write_1} = '0;
        addr_0 = 32'h0; wdata_0 = 32'h0; addr_1 = 32'h0; wdata_1 = 32'h0;
        data_mem_in = 32'h0; ready_mem = 1'b0;
        repeat (2) tick();
        check_idle("reset");
        reset = 1'b1;
        tick();

        // Single port-0 read burst.
        read_0 = 1'b1; addr_0 = 32'h100;
        #1 check("p0.pre_gnt", 32'(gnt_0), 32'd0);
        tick();
        check("p0.gnt", 32'(gnt_0), 32'd1);
        check("p0.read_mem", 32'(read_mem), 32'd1);
        check("p0.addr_mem", addr_mem, 32'h100);
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1; data_mem_in = 32'hA0 + 32'(i);
            #1;
            check($sformatf("p0.ready_w%0d", i), 32'(ready_0), 32'd1);
            check($sformatf("p0.rdata_w%0d", i), rdata_0, 32'hA0 + 32'(i));
            tick();
        end
        read_0 = 1'b0;
        #1 check_idle("p0.done");
        tick();
        check("p0.idle_ignores_ready", 32'(ready_0), 32'd0);
        ready_mem = 1'b0;
        tick();

        // Tie after reset: port 0, turnaround, port 1, then port 0 again.
        reset = 1'b0; #2 reset = 1'b1;
        read_0 = 1'b1; read_1 = 1'b1; addr_1 = 32'h300;
        tick();
        check("tie.gnt_first", {30'b0, gnt_1, gnt_0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1; data_mem_in = 32'hB0 + 32'(i);
            #1 check($sformatf("tie.p1_ready_w%0d", i), 32'(ready_1), 32'd0);
            tick();
        end
        ready_mem = 1'b0;
        check("tie.turnaround", {30'b0, gnt_1, gnt_0}, 32'd0);
        tick();
        check("tie.gnt_second", {30'b0, gnt_1, gnt_0}, 32'd2);
        check("tie.addr_mem", addr_mem, 32'h300);
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1; data_mem_in = 32'hC0 + 32'(i);
            #1 check($sformatf("tie.p1_rdata_w%0d", i), rdata_1, 32'hC0 + 32'(i));
            tick();
        end
        ready_mem = 1'b0;
        tick();
        check("tie.gnt_third", {30'b0, gnt_1, gnt_0}, 32'd1);
        read_0 = 1'b0; read_1 = 1'b0;
        tick();
        check("tie.release", {30'b0, gnt_1, gnt_0}, 32'd0);
        tick();

        // Port-1 write burst with port 0 contending mid-burst.
        write_1 = 1'b1; wdata_1 = 32'hDEADBEEF; addr_1 = 32'h200;
        tick();
        check("wr.gnt1", 32'(gnt_1), 32'd1);
        read_0 = 1'b1; addr_0 = 32'h400;
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1; data_mem_in = 32'h55;
            #1;
            check($sformatf("wr.gnt_w%0d", i), {30'b0, gnt_1, gnt_0}, 32'd2);
            check($sformatf("wr.write_mem_w%0d", i), {30'b0, write_mem, read_mem}, 32'd2);
            check($sformatf("wr.data_w%0d", i), data_mem_out, 32'hDEADBEEF);
            check($sformatf("wr.ready0_w%0d", i), 32'(ready_0), 32'd0);
            tick();
        end
        ready_mem = 1'b0; write_1 = 1'b0;
        check("wr.turnaround", {30'b0, gnt_1, gnt_0}, 32'd0);
        tick();

        // Port 0 early release after two words, then a full fresh burst.
        check("rel.gnt0", 32'(gnt_0), 32'd1);
        for (int i = 0; i < 2; i++) begin
            ready_mem = 1'b1;
            tick();
        end
        ready_mem = 1'b0; read_0 = 1'b0;
        #1 check("rel.still_gnt", 32'(gnt_0), 32'd1);
        tick();
        check("rel.idle", 32'(gnt_0), 32'd0);
        read_0 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1;
            #1 check($sformatf("rel.full_w%0d", i), 32'(gnt_0), 32'd1);
            tick();
        end
        ready_mem = 1'b0; read_0 = 1'b0;
        check("rel.full_done", 32'(gnt_0), 32'd0);
        tick();

        // Asynchronous reset in the middle of a port-1 burst.
        read_1 = 1'b1; addr_1 = 32'h600;
        tick();
        check("rst.gnt1", 32'(gnt_1), 32'd1);
        for (int i = 0; i < 2; i++) begin
            ready_mem = 1'b1;
            tick();
        end
        data_mem_in = 32'h77;
        #1 reset = 1'b0;
        #1 check_idle("rst.async");
        tick();
        check_idle("rst.held");
        read_0 = 1'b1; addr_0 = 32'h700; ready_mem = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("rst.after_tie", {30'b0, gnt_1, gnt_0}, 32'd1);
        read_0 = 1'b0; read_1 = 1'b0;
        tick();
        tick();

        // Simultaneous read and write on port 0: write wins.
        read_0 = 1'b1; write_0 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ready_mem = 1'b1;
            #1 check($sformatf("rw.mem_w%0d", i), {30'b0, write_mem, read_mem}, 32'd2);
            tick();
        end
        ready_mem = 1'b0; read_0 = 1'b0; write_0 = 1'b0;
        check_idle("rw.done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
